cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Round-robin arbiter that shares the single-port cache controller between NUM_REQ requesters, e.g. instruction fetch and data port.
- Accepts one request at a time using valid/ready and forwards it to the cache.
- Holds ownership until the cache responds, then routes the response back to the owner.
- Sits between the requester ports and the cache controller's request interface.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- TIMEOUT, 15, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept
- req_we  in  NUM_REQ  per-requester write flag
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owner
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- rsp_hit  out  1  hit flag of the response
- rsp_err  out  1  timeout error flag of the response
- c_req_valid  out  1  request to the cache
- c_req_ready  in  1  cache accepts the request
- c_we  out  1  write flag to the cache
- c_addr  out  ADDR_W  address to the cache
- c_wdata  out  DATA_W  write data to the cache
- c_rsp_valid  in  1  cache response strobe
- c_rdata  in  DATA_W  cache read data
- c_hit  in  1  cache hit flag
- busy  out  1  high in every state except IDLE
- grant_id  out  2  index of the current or last owner

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, round-robin pointer 0, captured registers 0.
- A reset mid-transaction abandons the transaction. Any later c_rsp_valid is ignored while in IDLE.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Winner = first i with req_valid[i] high, searching from the pointer upward with wrap modulo NUM_REQ.
  - req_ready[winner] is asserted combinationally in the same cycle; every other ready is 0.
  - On transfer: capture we/addr/wdata, grant_id <= winner, pointer <= (winner+1) mod NUM_REQ, go to ISSUE.
  - With no valid request: stay in IDLE and leave the pointer unchanged.
- ISSUE:
  - c_req_valid = 1, with c_we/c_addr/c_wdata driven from the captured registers.
  - Payload is held stable until c_req_ready is high; then go to WAIT.
  - All req_ready are 0 in this state.
- WAIT:
  - On c_rsp_valid: capture c_rdata and c_hit, go to RESP.
  - A c_rsp_valid outside WAIT is ignored. The cache contract guarantees at least 1 cycle between the accept and the response.
- RESP:
  - rsp_valid[grant_id] = 1 for exactly one cycle, with rsp_rdata/rsp_hit driven from the captured values.
  - For a write, rsp_rdata = 0.
  - Next state is IDLE.
- Minimum turnaround is 4 cycles per request: accept, issue, wait(≥1), resp.
- A new accept can happen in the cycle immediately after RESP.
- Requester rule: a requester keeps req_valid and its payload stable until it sees ready. Dropping valid before ready is permitted; the request is simply not taken.
- Fairness: a continuously requesting port is served within NUM_REQ grants.

Optional Feature:
- Macro: CACHE_ARB_TIMEOUT_EN.
- Enabled:
  - A 4-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT with no c_rsp_valid, go to RESP with rsp_err = 1, rsp_rdata = 0 and rsp_hit = 0.
  - If c_rsp_valid arrives in the same cycle as the timeout, the response wins and rsp_err = 0.
- Disabled: WAIT lasts indefinitely and rsp_err is tied to 0.

Decomposition:
- Shared package cache_pkg holds:
  - the FSM state typedef (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the ADDR_W and DATA_W defaults;
  - the response struct {rdata, hit, err}.
- One sub-module, rr_pick: a combinational round-robin picker taking req_valid and the pointer, producing winner index and any_valid.
  - It is reusable by future write-buffer arbitration.
- The FSM and datapath registers stay in cache_req_arbiter.

Test Plan:
- After rst, all outputs are 0. Req0 write addr 0x04 data 0xA5 → req_ready[0] in the same cycle; c_req_valid with c_addr 0x04, c_we=1, c_wdata 0xA5. Cache acks, then c_rsp_valid 2 cycles later → rsp_valid[0] one pulse.
- Req0 read 0x04, cache returns rdata 0xA5 with hit=1 → rsp_valid[0]=1, rsp_rdata 0xA5, rsp_hit 1. rsp_valid[1] stays 0 throughout.
- Req0 and req1 both assert valid continuously for 4 transactions → grant order 0,1,0,1; grant_id matches each response.
- c_req_ready held low for 5 cycles → c_req_valid and the c_addr/c_wdata payload stay stable; no req_ready is asserted until RESP completes.
- rst asserted during WAIT, then a late c_rsp_valid arrives → no rsp_valid; busy 0; the next request is granted to req0 (pointer reset).
- With CACHE_ARB_TIMEOUT_EN defined and no cache response → rsp_err=1 on rsp_valid[owner] exactly TIMEOUT=15 cycles after entering WAIT. Without the macro, busy stays 1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache request arbiter: FSM state,
// default widths and the captured cache response bundle.
package cache_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  hit;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or
// above ptr, wrapping modulo N. Ports: valid, ptr -> winner, any_valid.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] valid,
  input  logic [1:0]   ptr,
  output logic [1:0]   winner,
  output logic         any_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Scan from the farthest offset down so the nearest valid
  // index above the pointer is the one left in winner.
  always_comb begin
    winner    = '0;
    any_valid = |valid;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[IW'((int'(ptr) + k) % N)])
        winner = 2'((int'(ptr) + k) % N);
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache port among NUM_REQ
// requesters. Ports: req_* (requesters), rsp_* (responses),
// c_* (cache side), busy, grant_id. Optional WAIT timeout is
// enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  output logic                  c_req_valid,
  input  logic                  c_req_ready,
  output logic                  c_we,
  output logic [ADDR_W-1:0]     c_addr,
  output logic [DATA_W-1:0]     c_wdata,
  input  logic                  c_rsp_valid,
  input  logic [DATA_W-1:0]     c_rdata,
  input  logic                  c_hit,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

  arb_state_t state, nxt;
  logic [1:0] ptr, grant_q, winner;
  logic any_valid, take, tmo;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  rsp_t rsp_q;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign take = (state == IDLE) && any_valid;

`ifdef CACHE_ARB_TIMEOUT_EN
  logic [3:0] cnt;
  // cnt is 0 in the first WAIT cycle, so TIMEOUT WAIT cycles
  // have elapsed when it shows TIMEOUT-1.
  assign tmo = (state == WAIT) && (cnt == 4'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt         = state;
    req_ready   = '0;
    rsp_valid   = '0;
    c_req_valid = 1'b0;
    rsp_rdata   = '0;
    rsp_hit     = 1'b0;
    rsp_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready = NUM_REQ'(1) << winner;
          nxt       = ISSUE;
        end
      end
      ISSUE: begin
        c_req_valid = 1'b1;
        if (c_req_ready) nxt = WAIT;
      end
      WAIT: begin
        if (c_rsp_valid || tmo) nxt = RESP;
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << grant_q;
        rsp_rdata = rsp_q.rdata;
        rsp_hit   = rsp_q.hit;
        rsp_err   = rsp_q.err;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      if (take) begin
        we_q    <= req_we[IW'(winner)];
        addr_q  <= ADDR_W'(req_addr >> (int'(winner) * ADDR_W));
        wdata_q <= DATA_W'(req_wdata >> (int'(winner) * DATA_W));
        grant_q <= winner;
        ptr     <= (winner == LAST) ? 2'd0 : winner + 2'd1;
      end
      // A real response beats a timeout in the same cycle.
      if (state == WAIT && c_rsp_valid) begin
        rsp_q.rdata <= we_q ? '0 : c_rdata;
        rsp_q.hit   <= c_hit;
        rsp_q.err   <= 1'b0;
      end else if (tmo) begin
        rsp_q.rdata <= '0;
        rsp_q.hit   <= 1'b0;
        rsp_q.err   <= 1'b1;
      end
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state == ISSUE) cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + 4'd1;
  end
`endif

  assign busy     = (state != IDLE);
  assign grant_id = grant_q;
  assign c_we     = we_q;
  assign c_addr   = addr_q;
  assign c_wdata  = wdata_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: transaction-level model plus
// directed scenarios and a randomized soak.
module tb_cache_req_arbiter;

  localparam int N   = 2;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 15;
`ifdef CACHE_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic rsp_hit, rsp_err;
  logic c_req_valid;
  logic c_req_ready = 1'b0;
  logic c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic c_rsp_valid = 1'b0;
  logic [DW-1:0] c_rdata = '0;
  logic c_hit = 1'b0;
  logic busy;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  cache_req_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .c_hit(c_hit), .busy(busy), .grant_id(grant_id)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding transaction,
  // described as "free", "issued to cache", "response due".
  bit m_free = 1'b1, m_issued = 1'b0, m_due = 1'b0;
  int m_ptr = 0, m_grant = 0, m_wait = 0;
  logic m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic m_hit = 1'b0, m_err = 1'b0;
  bit chk_on = 1'b0;
  int grant_log[$];
  int rsp_log[$];

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_free = 1; m_issued = 0; m_due = 0;
      m_ptr = 0; m_grant = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0;
      m_hit = 0; m_err = 0;
    end else if (m_due) begin
      m_due = 0; m_free = 1;
    end else if (m_free) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_we = req_we[w];
        m_addr = req_addr[w*AW +: AW];
        m_wdata = req_wdata[w*DW +: DW];
        m_grant = w;
        m_ptr = (w + 1) % N;
        m_free = 0; m_issued = 0;
      end
    end else if (!m_issued) begin
      if (c_req_ready) begin
        m_issued = 1; m_wait = 0;
      end
    end else begin
      m_wait++;
      if (c_rsp_valid) begin
        m_due = 1; m_err = 0;
        m_rdata = m_we ? '0 : c_rdata;
        m_hit = c_hit;
      end else if (TEN && m_wait == TMO) begin
        m_due = 1; m_err = 1;
        m_rdata = 0; m_hit = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic [N-1:0] er;
    if (chk_on) begin
      er = '0;
      if (m_free) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) er[w] = 1'b1;
      end
      chk("ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(!m_free));
      chk("grant_id", 32'(grant_id), 32'(m_grant));
      chk("c_req_valid", 32'(c_req_valid),
          32'(!m_free && !m_issued));
      if (!m_free && !m_issued) begin
        chk("c_we", 32'(c_we), 32'(m_we));
        chk("c_addr", 32'(c_addr), 32'(m_addr));
        chk("c_wdata", 32'(c_wdata), 32'(m_wdata));
      end
      chk("rsp_valid", 32'(rsp_valid),
          m_due ? 32'(1) << m_grant : 32'(0));
      if (m_due) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_hit", 32'(rsp_hit), 32'(m_hit));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
        if (rsp_valid[i]) rsp_log.push_back(i);
      end
    end
  end

  // Cache agent: directed timing or random.
  bit rnd_mode = 0, no_rsp = 0, late_rsp = 0;
  int rdy_delay = 0, rsp_delay = 2;
  logic [DW-1:0] dir_rdata = '0;
  logic dir_hit = 1'b0;

  initial begin
    bit s_acc, s_cv, pend;
    int icnt, w;
    pend = 0; icnt = 0; w = 0;
    forever begin
      @(negedge clk);
      s_acc = c_req_valid & c_req_ready;
      s_cv = c_req_valid;
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        c_req_ready = 1'($urandom % 2);
        c_rsp_valid = ($urandom % 4 == 0);
        c_rdata = DW'($urandom);
        c_hit = 1'($urandom);
        pend = 0;
      end else begin
        icnt = (s_cv && !s_acc) ? icnt + 1 : 0;
        c_req_ready = (icnt >= rdy_delay);
        c_rdata = dir_rdata;
        c_hit = dir_hit;
        if (s_acc) begin pend = 1; w = 0; end
        c_rsp_valid = 1'b0;
        if (pend) begin
          w++;
          if (w == rsp_delay && !no_rsp) begin
            c_rsp_valid = 1'b1; pend = 0;
          end
        end
        if (late_rsp) begin
          c_rsp_valid = 1'b1; late_rsp = 0;
        end
      end
    end
  end

  task automatic send(int p, logic we, logic [AW-1:0] a,
                      logic [DW-1:0] d, output int lat);
    @(posedge clk); #1;
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
    lat = 0;
    @(negedge clk);
    while (!req_ready[p] && lat < 50) begin
      lat++; @(negedge clk);
    end
    if (lat >= 50) chk("accept_bound", 0, 1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (rsp_valid == 0 && n < 100) begin
      n++; @(negedge clk);
    end
    if (n >= 100) chk("rsp_bound", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int lat, n, gb, rb, ic;
    logic [N-1:0] acc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_creq", 32'(c_req_valid), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_caddr", 32'(c_addr), 0);

    // write from port 0
    dir_rdata = 8'h33;
    send(0, 1'b1, 8'h04, 8'hA5, lat);
    chk("t1_lat", lat, 0);
    @(negedge clk);
    chk("t1_creq", 32'(c_req_valid), 1);
    chk("t1_we", 32'(c_we), 1);
    chk("t1_addr", 32'(c_addr), 32'h04);
    chk("t1_wdata", 32'(c_wdata), 32'hA5);
    wait_rsp(n);
    chk("t1_rsp_lat", n, 2);
    chk("t1_rsp", 32'(rsp_valid), 1);
    chk("t1_rdata", 32'(rsp_rdata), 0);
    @(negedge clk);
    chk("t1_pulse", 32'(rsp_valid), 0);
    chk("t1_idle", 32'(busy), 0);

    // read hit from port 0
    dir_rdata = 8'hA5; dir_hit = 1'b1;
    send(0, 1'b0, 8'h04, 8'h00, lat);
    wait_rsp(n);
    chk("t2_rsp", 32'(rsp_valid), 1);
    chk("t2_rdata", 32'(rsp_rdata), 32'hA5);
    chk("t2_hit", 32'(rsp_hit), 1);

    // both ports continuously: alternation from pointer 0
    do_reset();
    gb = grant_log.size(); rb = rsp_log.size();
    @(posedge clk); #1;
    req_we = 2'b01;
    req_addr = {8'h20, 8'h10};
    req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() < gb + 4 && n < 200) begin
      n++; @(negedge clk);
    end
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    while (rsp_log.size() < rb + 4 && n < 200) begin
      n++; @(negedge clk);
    end
    if (n >= 200) chk("t3_bound", 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", grant_log.size() > gb + i ?
          grant_log[gb + i] : -1, i % 2);
      chk("t3_rsp", rsp_log.size() > rb + i ?
          rsp_log[rb + i] : -1, i % 2);
    end

    // cache stalls the request for 5 cycles
    rdy_delay = 5;
    send(1, 1'b1, 8'h3C, 8'h5A, lat);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[7:0] = 8'h77;
    ic = 0;
    @(negedge clk);
    while (c_req_valid && ic < 20) begin
      ic++;
      chk("t4_addr", 32'(c_addr), 32'h3C);
      chk("t4_wdata", 32'(c_wdata), 32'h5A);
      chk("t4_noready", 32'(req_ready), 0);
      @(negedge clk);
    end
    chk("t4_issue_cycles", ic, 6);
    rdy_delay = 0;
    wait_rsp(n);
    chk("t4_rsp", 32'(rsp_valid), 2);
    @(negedge clk);
    chk("t4_next_accept", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(n);

    // reset during WAIT, then a late response
    no_rsp = 1;
    send(0, 1'b0, 8'h11, 8'h00, lat);
    repeat (3) @(negedge clk);
    chk("t5_waiting", 32'(busy), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); late_rsp = 1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_late_rsp", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t5_late_rsp2", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    no_rsp = 0;
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_ptr_reset", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(n);

    // cache never answers
    no_rsp = 1;
    send(0, 1'b0, 8'h42, 8'h00, lat);
    @(negedge clk);
    n = 0;
    @(negedge clk);
    while (rsp_valid == 0 && n < 40) begin
      n++; @(negedge clk);
    end
`ifdef CACHE_ARB_TIMEOUT_EN
    chk("t6_tmo_cycles", n, TMO);
    chk("t6_err", 32'(rsp_err), 1);
    chk("t6_rsp", 32'(rsp_valid), 1);
`else
    chk("t6_no_tmo", n, 40);
    chk("t6_busy", 32'(busy), 1);
`endif
    no_rsp = 0;
    do_reset();

    // randomized soak
    rnd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc[i]) begin
          if ($urandom % 8 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 2 == 1) begin
          req_valid[i] = 1'b1;
          req_we[i] = 1'($urandom);
          req_addr[i*AW +: AW] = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    rnd_mode = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
